// File: rtl/pp_bank_ctrl.sv
// pp_bank_ctrl
//   Controller for a single-port ping-pong buffer pair. The producer writes words
//   into the bank currently filling over a valid/ready handshake. The other bank,
//   once full, is drained to the systolic array one module slice at a time.
//   Banks swap roles when each side completes.
//
// Ports
//   clk, rst_n                     clock, asynchronous active-low reset
//   in_valid / in_ready            producer handshake (din goes straight to the RAM)
//   sa_ready                       systolic array accepts a read issue this cycle
//   bankN_ena/_wea/_addra          per-bank RAM port controls (addr is 0 when ena is 0)
//   out_valid/out_bank/out_last    issue-cycle info delayed by READ_LATENCY
//   slicing_idx                    module slice of the word on out_valid
//   bank_full                      registered per-bank FULL/DRAINING status
//   wr_stall_cnt                   saturating count of cycles with in_valid && !in_ready
//
// Build option
//   PP_CTRL_STALL_CNT_EN  defined: the stall counter is built.
//                         undefined: wr_stall_cnt is tied to 0.

module pp_bank_ctrl #(
  parameter int unsigned DEPTH         = 16,
  parameter int unsigned TOTAL_MODULES = 4,
  parameter int unsigned READ_LATENCY  = 2,
  parameter int unsigned ADDR_WIDTH    = $clog2(DEPTH)
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic                  sa_ready,
  output logic                  bank0_ena,
  output logic                  bank1_ena,
  output logic                  bank0_wea,
  output logic                  bank1_wea,
  output logic [ADDR_WIDTH-1:0] bank0_addra,
  output logic [ADDR_WIDTH-1:0] bank1_addra,
  output logic [(TOTAL_MODULES > 1 ? $clog2(TOTAL_MODULES) : 1)-1:0] slicing_idx,
  output logic                  out_valid,
  output logic                  out_bank,
  output logic                  out_last,
  output logic [1:0]            bank_full,
  output logic [15:0]           wr_stall_cnt
);

  localparam int unsigned SLICE_WIDTH = (TOTAL_MODULES > 1) ? $clog2(TOTAL_MODULES) : 1;

  typedef enum logic [1:0] {
    EMPTY    = 2'd0,
    FILLING  = 2'd1,
    FULL     = 2'd2,
    DRAINING = 2'd3
  } bank_state_t;

  bank_state_t            state_q [2];
  bank_state_t            state_d [2];
  logic                   run;
  logic                   wr_sel, rd_sel;
  logic [ADDR_WIDTH-1:0]  wr_addr, rd_addr;
  logic [SLICE_WIDTH-1:0] slice;
  logic [1:0]             loaded;
  logic                   wr_fire, rd_fire, wr_last, rd_last;
  logic [1:0]             wr_hit, rd_hit;

  // run is low in reset and for the first edge after release, so the handshake
  // stays closed while rst_n is asserted even though both banks read EMPTY.
  always_comb begin
    loaded[0] = (state_q[0] == FULL) || (state_q[0] == DRAINING);
    loaded[1] = (state_q[1] == FULL) || (state_q[1] == DRAINING);
  end

  assign in_ready = run && !loaded[wr_sel];
  assign wr_fire  = in_valid && in_ready;
  assign rd_fire  = run && loaded[rd_sel] && sa_ready;
  assign wr_last  = wr_fire && (wr_addr == ADDR_WIDTH'(DEPTH - 1));
  assign rd_last  = rd_fire && (rd_addr == ADDR_WIDTH'(DEPTH - 1)) &&
                    (slice == SLICE_WIDTH'(TOTAL_MODULES - 1));
  assign wr_hit   = {wr_fire & wr_sel, wr_fire & ~wr_sel};
  assign rd_hit   = {rd_fire & rd_sel, rd_fire & ~rd_sel};

  always_comb begin
    for (int unsigned b = 0; b < 2; b++) begin
      state_d[b] = state_q[b];
      if (wr_hit[b])      state_d[b] = wr_last ? FULL : FILLING;
      else if (rd_hit[b]) state_d[b] = rd_last ? EMPTY : DRAINING;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      run        <= 1'b0;
      state_q[0] <= EMPTY;
      state_q[1] <= EMPTY;
      wr_sel     <= 1'b0;
      rd_sel     <= 1'b0;
      wr_addr    <= '0;
      rd_addr    <= '0;
      slice      <= '0;
      bank_full  <= '0;
    end else begin
      run        <= 1'b1;
      state_q[0] <= state_d[0];
      state_q[1] <= state_d[1];
      bank_full  <= loaded;
      if (wr_fire) begin
        wr_addr <= wr_last ? '0 : wr_addr + 1'b1;
        if (wr_last) wr_sel <= ~wr_sel;
      end
      if (rd_fire) begin
        if (rd_addr == ADDR_WIDTH'(DEPTH - 1)) begin
          rd_addr <= '0;
          if (rd_last) begin
            slice  <= '0;
            rd_sel <= ~rd_sel;
          end else begin
            slice <= slice + 1'b1;
          end
        end else begin
          rd_addr <= rd_addr + 1'b1;
        end
      end
    end
  end

  // RAM port controls: write and read can never target the same bank in one cycle.
  assign bank0_ena   = wr_hit[0] | rd_hit[0];
  assign bank1_ena   = wr_hit[1] | rd_hit[1];
  assign bank0_wea   = wr_hit[0];
  assign bank1_wea   = wr_hit[1];
  assign bank0_addra = wr_hit[0] ? wr_addr : (rd_hit[0] ? rd_addr : '0);
  assign bank1_addra = wr_hit[1] ? wr_addr : (rd_hit[1] ? rd_addr : '0);

  assert property (@(posedge clk) disable iff (!rst_n)
                   !(wr_fire && rd_fire && (wr_sel == rd_sel)));

  // Read-side pipeline; side info is zeroed on idle cycles so it only ever
  // carries meaning alongside out_valid.
  logic [READ_LATENCY-1:0] v_pipe, b_pipe, l_pipe;
  logic [SLICE_WIDTH-1:0]  s_pipe [READ_LATENCY];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      v_pipe <= '0;
      b_pipe <= '0;
      l_pipe <= '0;
      for (int unsigned i = 0; i < READ_LATENCY; i++) s_pipe[i] <= '0;
    end else begin
      v_pipe[0] <= rd_fire;
      b_pipe[0] <= rd_fire & rd_sel;
      l_pipe[0] <= rd_last;
      s_pipe[0] <= rd_fire ? slice : '0;
      for (int unsigned i = 1; i < READ_LATENCY; i++) begin
        v_pipe[i] <= v_pipe[i-1];
        b_pipe[i] <= b_pipe[i-1];
        l_pipe[i] <= l_pipe[i-1];
        s_pipe[i] <= s_pipe[i-1];
      end
    end
  end

  assign out_valid   = v_pipe[READ_LATENCY-1];
  assign out_bank    = b_pipe[READ_LATENCY-1];
  assign out_last    = l_pipe[READ_LATENCY-1];
  assign slicing_idx = s_pipe[READ_LATENCY-1];

`ifdef PP_CTRL_STALL_CNT_EN
  logic [15:0] stall_cnt;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)
      stall_cnt <= '0;
    else if (run && in_valid && !in_ready && (stall_cnt != '1))
      stall_cnt <= stall_cnt + 1'b1;
  end

  assign wr_stall_cnt = stall_cnt;
`else
  assign wr_stall_cnt = '0;
`endif

endmodule

// File: tb/tb_pp_bank_ctrl.sv
// Testbench for pp_bank_ctrl with a behavioural two-bank RAM. Directed stimulus
// pushes expected write accesses, read issues and output words into queues;
// monitors on the falling edge pop and compare whenever the DUT acts.

module tb_pp_bank_ctrl;

  localparam int DEPTH = 16;
  localparam int TM    = 4;
  localparam int RL    = 2;

  logic        clk = 1'b0, rst_n = 1'b0, in_valid = 1'b0, sa_ready = 1'b0;
  logic        in_ready, bank0_ena, bank1_ena, bank0_wea, bank1_wea;
  logic [3:0]  bank0_addra, bank1_addra;
  logic [1:0]  slicing_idx, bank_full;
  logic        out_valid, out_bank, out_last;
  logic [15:0] wr_stall_cnt;
  logic [15:0] din = '0;

  int checks = 0, errors = 0, cyc = 0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  pp_bank_ctrl #(.DEPTH(DEPTH), .TOTAL_MODULES(TM), .READ_LATENCY(RL)) dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
    .sa_ready(sa_ready), .bank0_ena(bank0_ena), .bank1_ena(bank1_ena),
    .bank0_wea(bank0_wea), .bank1_wea(bank1_wea), .bank0_addra(bank0_addra),
    .bank1_addra(bank1_addra), .slicing_idx(slicing_idx), .out_valid(out_valid),
    .out_bank(out_bank), .out_last(out_last), .bank_full(bank_full),
    .wr_stall_cnt(wr_stall_cnt)
  );

  // Behavioural RAMs with a two-cycle read (matches READ_LATENCY).
  logic [15:0] mem [2][DEPTH];
  logic [15:0] s1 [2];
  logic [15:0] dout [2];
  always @(posedge clk) begin
    if (bank0_ena && bank0_wea)  mem[0][bank0_addra] <= din;
    if (bank0_ena && !bank0_wea) s1[0] <= mem[0][bank0_addra];
    if (bank1_ena && bank1_wea)  mem[1][bank1_addra] <= din;
    if (bank1_ena && !bank1_wea) s1[1] <= mem[1][bank1_addra];
    dout[0] <= s1[0];
    dout[1] <= s1[1];
  end

  typedef struct packed { logic bank; logic [3:0] addr; } acc_t;
  typedef struct packed { logic bank; logic [1:0] slice; logic last; logic [15:0] data; } out_t;

  acc_t wq[$], rq[$];
  out_t oq[$];
  int   lat_q[$];
  logic [15:0] fillword [2][DEPTH];
  logic m_wr_sel = 1'b0, m_rd_sel = 1'b0;
  int   wr_ptr = 0;
  logic [15:0] wcnt = 16'h1000;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic mon_bank(input int b, input logic ena, input logic wea, input logic [3:0] addr);
    acc_t e;
    if (ena && wea) begin
      if (wq.size() == 0) check("wr_unexpected", 1, 0);
      else begin
        e = wq.pop_front();
        check("wr_bank", 32'(b), 32'(e.bank));
        check("wr_addr", 32'(addr), 32'(e.addr));
      end
    end else if (ena) begin
      lat_q.push_back(cyc);
      if (rq.size() == 0) check("rd_unexpected", 1, 0);
      else begin
        e = rq.pop_front();
        check("rd_bank", 32'(b), 32'(e.bank));
        check("rd_addr", 32'(addr), 32'(e.addr));
      end
    end else begin
      check("idle_addr_zero", 32'(addr), 0);
    end
  endtask

  always @(negedge clk) begin
    out_t e;
    if (rst_n) begin
      mon_bank(0, bank0_ena, bank0_wea, bank0_addra);
      mon_bank(1, bank1_ena, bank1_wea, bank1_addra);
      if (out_valid) begin
        if (oq.size() == 0) check("out_unexpected", 1, 0);
        else begin
          e = oq.pop_front();
          check("out_bank", 32'(out_bank), 32'(e.bank));
          check("out_slice", 32'(slicing_idx), 32'(e.slice));
          check("out_last", 32'(out_last), 32'(e.last));
          check("out_data", 32'(dout[out_bank]), 32'(e.data));
        end
        if (lat_q.size() == 0) check("out_no_issue", 1, 0);
        else check("out_latency", 32'(cyc - lat_q.pop_front()), RL);
      end
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic push_write();
    acc_t e;
    e.bank = m_wr_sel;
    e.addr = 4'(wr_ptr);
    wq.push_back(e);
    fillword[m_wr_sel][wr_ptr] = din;
    wr_ptr++;
    if (wr_ptr == DEPTH) begin
      wr_ptr   = 0;
      m_wr_sel = ~m_wr_sel;
    end
  endtask

  task automatic fill(input int n);
    for (int i = 0; i < n; i++) begin
      din      = wcnt;
      wcnt     = wcnt + 16'd1;
      in_valid = 1'b1;
      push_write();
      @(negedge clk);
      check("in_ready_fill", 32'(in_ready), 1);
      step();
    end
    in_valid = 1'b0;
  endtask

  task automatic plan_drain();
    acc_t a;
    out_t o;
    for (int s = 0; s < TM; s++)
      for (int w = 0; w < DEPTH; w++) begin
        a.bank = m_rd_sel;  a.addr = 4'(w);
        rq.push_back(a);
        o.bank = m_rd_sel;  o.slice = 2'(s);
        o.last = (s == TM - 1) && (w == DEPTH - 1);
        o.data = fillword[m_rd_sel][w];
        oq.push_back(o);
      end
    m_rd_sel = ~m_rd_sel;
  endtask

  task automatic run_sa(input int n);
    sa_ready = 1'b1;
    repeat (n) step();
    sa_ready = 1'b0;
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation did not complete (cycle %0d)", cyc);
    $fatal(1);
  end

  initial begin
    acc_t a;
    out_t o;

    // Reset with inputs active.
    rst_n = 1'b0; in_valid = 1'b1; sa_ready = 1'b1;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("reset_in_ready", 32'(in_ready), 0);
    check("reset_ctrl", 32'({bank0_ena, bank1_ena, bank0_wea, bank1_wea, bank0_addra, bank1_addra}), 0);
    check("reset_out", 32'({out_valid, out_bank, out_last, slicing_idx, bank_full}), 0);
    check("reset_stall", 32'(wr_stall_cnt), 0);
    @(posedge clk); #1;
    rst_n = 1'b1; in_valid = 1'b0; sa_ready = 1'b0;
    step();
    @(negedge clk);
    check("in_ready_after_release", 32'(in_ready), 1);
    step();

    // Continuous fill of both banks, no draining.
    fill(21);
    @(negedge clk);
    check("bank_full_one", 32'(bank_full), 32'b01);
    step();
    fill(11);
    in_valid = 1'b1;
    repeat (10) begin
      @(negedge clk);
      check("in_ready_both_full", 32'(in_ready), 0);
      step();
    end
    in_valid = 1'b0;
    @(negedge clk);
    check("bank_full_both", 32'(bank_full), 32'b11);
`ifdef PP_CTRL_STALL_CNT_EN
    check("stall_cnt", 32'(wr_stall_cnt), 10);
`else
    check("stall_cnt", 32'(wr_stall_cnt), 0);
`endif
    step();

    // Drain bank0 with sa_ready held high.
    plan_drain();
    run_sa(64);
    repeat (4) step();
    @(negedge clk);
    check("in_ready_after_drain", 32'(in_ready), 1);
    check("bank_full_after_drain", 32'(bank_full), 32'b10);
    step();

    // Drain bank1 with sa_ready toggling.
    plan_drain();
    repeat (64) begin
      sa_ready = 1'b1; step();
      sa_ready = 1'b0; step();
    end
    repeat (4) step();
    @(negedge clk);
    check("bank_full_empty", 32'(bank_full), 32'b00);
    check("in_ready_empty", 32'(in_ready), 1);
    step();

    // Final fill beat of bank1 coincides with the final issue of bank0.
    fill(16);
    fill(15);
    plan_drain();
    sa_ready = 1'b1;
    repeat (63) step();
    din = wcnt; wcnt = wcnt + 16'd1; in_valid = 1'b1;
    push_write();
    step();
    in_valid = 1'b0;
    plan_drain();
    fill(16);
    plan_drain();
    repeat (112) step();
    sa_ready = 1'b0;
    repeat (4) step();
    @(negedge clk);
    check("bank_full_after_swap", 32'(bank_full), 32'b00);
    check("queues_after_swap", 32'(wq.size() + rq.size() + oq.size()), 0);
    step();

    // Reset in the middle of a drain (bank1 is next for both pointers).
    fill(16);
    for (int i = 0; i < 22; i++) begin
      a.bank = 1'b1; a.addr = 4'(i % DEPTH);
      rq.push_back(a);
    end
    for (int i = 0; i < 20; i++) begin
      o.bank = 1'b1; o.slice = 2'(i / DEPTH); o.last = 1'b0;
      o.data = fillword[1][i % DEPTH];
      oq.push_back(o);
    end
    sa_ready = 1'b1;
    repeat (22) step();
    rst_n = 1'b0; sa_ready = 1'b0;
    #1;
    check("out_valid_drop", 32'(out_valid), 0);
    check("ena_drop", 32'({bank0_ena, bank1_ena}), 0);
    lat_q.delete();
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("out_valid_in_reset", 32'(out_valid), 0);
    @(posedge clk); #1;
    rst_n = 1'b1;
    repeat (5) step();
    @(negedge clk);
    check("bank_full_post_reset", 32'(bank_full), 32'b00);
    check("in_ready_post_reset", 32'(in_ready), 1);
    check("queues_post_reset", 32'(wq.size() + rq.size() + oq.size()), 0);
    step();

    // Both pointers restart at bank0.
    m_wr_sel = 1'b0; m_rd_sel = 1'b0; wr_ptr = 0;
    fill(16);
    plan_drain();
    run_sa(64);
    repeat (5) step();
    @(negedge clk);
    check("queues_final", 32'(wq.size() + rq.size() + oq.size()), 0);
    check("bank_full_final", 32'(bank_full), 32'b00);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
